// File: rtl/rle_compressor_if.sv
// rle_compressor_if -- stream bundle for the RLE compressor.
//   din/in_valid/in_last/in_ready   : raw bitmap input stream (16-bit words)
//   dout/out_valid/out_last/out_ready : compressed output stream (RUN_W-bit words)
// Modports:
//   master : producer of din / consumer of dout (testbench, upstream+downstream)
//   slave  : the compressor itself
interface rle_compressor_if #(
  parameter int unsigned RUN_W = 16
);
  logic [15:0]      din;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [RUN_W-1:0] dout;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (
    output din, in_valid, in_last, out_ready,
    input  in_ready, dout, out_valid, out_last
  );

  modport slave (
    input  din, in_valid, in_last, out_ready,
    output in_ready, dout, out_valid, out_last
  );
endinterface

// File: rtl/rle_compressor.sv
// rle_compressor -- run-length encoder for a 1-bit bitmap stream.
// Each stream starts with a header word holding the value of the first bit,
// followed by alternating run lengths (bit 0 of each input word consumed
// first). Runs span input-word boundaries. A run that would overflow the
// RUN_W-bit counter is split as all-ones, then a zero-length opposite run.
// Ports:
//   clk             : clock, rising edge
//   rst             : synchronous, active-high reset
//   bus (slave)     : din/in_valid/in_last/in_ready input stream,
//                     dout/out_valid/out_last/out_ready output stream
//   words_in/out    : handshaked word counters (only with RLE_STATS_EN)
// Build option: define RLE_STATS_EN to add the words_in/words_out counters.
module rle_compressor #(
  parameter int unsigned RUN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  rle_compressor_if.slave   bus
`ifdef RLE_STATS_EN
  ,
  output logic [15:0]       words_in,
  output logic [15:0]       words_out
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] SCAN      = 3'd2;
  localparam logic [2:0] EMIT      = 3'd3;
  localparam logic [2:0] EMIT_LAST = 3'd4;

  logic [2:0]       r_state;
  logic [15:0]      r_word;
  logic             r_last;
  logic             r_cur_bit;
  logic [RUN_W-1:0] r_run;
  // bit 4 set means the index has wrapped past bit 15 of the latched word
  logic [4:0]       r_idx;
  logic [RUN_W-1:0] r_dout;
  logic             r_out_last;
  // a zero-length run still owed after an all-ones overflow word
  logic             r_zero_pend;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_bit;

  assign w_in_ready  = !rst && ((r_state == IDLE) || (r_state == LOAD));
  assign w_out_valid = (r_state == EMIT) || (r_state == EMIT_LAST);
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && bus.out_ready;
  assign w_bit       = r_word[r_idx[3:0]];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.dout      = r_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_last      <= 1'b0;
      r_cur_bit   <= 1'b0;
      r_run       <= '0;
      r_idx       <= '0;
      r_dout      <= '0;
      r_out_last  <= 1'b0;
      r_zero_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_word     <= bus.din;
            r_last     <= bus.in_last;
            r_cur_bit  <= bus.din[0];
            r_run      <= '0;
            r_idx      <= '0;
            r_dout     <= RUN_W'(bus.din[0]);
            r_out_last <= 1'b0;
            r_state    <= EMIT;
          end
        end

        LOAD: begin
          if (w_in_fire) begin
            r_word  <= bus.din;
            r_last  <= bus.in_last;
            r_idx   <= '0;
            r_state <= SCAN;
          end
        end

        SCAN: begin
          // the examined bit is always consumed here, so the index advances
          // even when an emit interrupts the scan
          r_idx <= r_idx + 5'd1;
          if (w_bit != r_cur_bit) begin
            r_dout    <= r_run;
            r_run     <= RUN_W'(1);
            r_cur_bit <= w_bit;
            r_state   <= EMIT;
          end else if (r_run == '1) begin
            r_dout      <= '1;
            r_zero_pend <= 1'b1;
            r_run       <= RUN_W'(1);
            r_state     <= EMIT;
          end else begin
            r_run <= r_run + RUN_W'(1);
            if (r_idx[3:0] == 4'd15) begin
              if (r_last) begin
                r_dout     <= r_run + RUN_W'(1);
                r_out_last <= 1'b1;
                r_state    <= EMIT_LAST;
              end else begin
                r_state <= LOAD;
              end
            end
          end
        end

        EMIT: begin
          if (w_out_fire) begin
            if (r_zero_pend) begin
              r_dout      <= '0;
              r_zero_pend <= 1'b0;
            end else if (r_idx[4]) begin
              // split happened on bit 15: close the word like SCAN would
              if (r_last) begin
                r_dout     <= r_run;
                r_out_last <= 1'b1;
                r_state    <= EMIT_LAST;
              end else begin
                r_state <= LOAD;
              end
            end else begin
              r_state <= SCAN;
            end
          end
        end

        EMIT_LAST: begin
          if (w_out_fire) begin
            r_out_last <= 1'b0;
            r_run      <= '0;
            r_cur_bit  <= 1'b0;
            r_idx      <= '0;
            r_state    <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RLE_STATS_EN
  logic [15:0] r_words_in;
  logic [15:0] r_words_out;

  always_ff @(posedge clk) begin
    if (rst || ((r_state == EMIT_LAST) && w_out_fire)) begin
      r_words_in  <= '0;
      r_words_out <= '0;
    end else begin
      if (w_in_fire && (r_words_in != 16'hFFFF))
        r_words_in <= r_words_in + 16'd1;
      if (w_out_fire && (r_words_out != 16'hFFFF))
        r_words_out <= r_words_out + 16'd1;
    end
  end

  assign words_in  = r_words_in;
  assign words_out = r_words_out;
`endif

endmodule

// File: tb/tb_rle_compressor.sv
// tb_rle_compressor -- randomized self-checking bench for rle_compressor.
// Expected output streams come from a run-length model over the flattened
// bit stream of each input stimulus.
module tb_rle_compressor;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rle_compressor_if #(.RUN_W(16)) bus ();

`ifdef RLE_STATS_EN
  logic [15:0] words_in;
  logic [15:0] words_out;
`endif

  rle_compressor #(.RUN_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RLE_STATS_EN
    ,
    .words_in(words_in),
    .words_out(words_out)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] sw[$];
  logic [16:0] exp_q[$];
  logic [16:0] out_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // one maximal run of identical bits; overflowing lengths split into
  // all-ones + zero-length opposite run pieces
  task automatic push_run(input int unsigned len, input bit last);
    int unsigned l;
    l = len;
    while (l > 65535) begin
      exp_q.push_back({1'b0, 16'hFFFF});
      exp_q.push_back({1'b0, 16'h0000});
      l -= 65535;
    end
    exp_q.push_back({last, 16'(l)});
  endtask

  task automatic build_model();
    int unsigned run;
    bit cur;
    logic [15:0] w;
    exp_q.delete();
    run = 0;
    w = sw[0];
    cur = w[0];
    exp_q.push_back({1'b0, 15'd0, cur});
    foreach (sw[i]) begin
      w = sw[i];
      for (int b = 0; b < 16; b++) begin
        if (w[b] == cur) run++;
        else begin
          push_run(run, 1'b0);
          cur = w[b];
          run = 1;
        end
      end
    end
    push_run(run, 1'b1);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    case ($urandom_range(0, 4))
      0:       w = 16'h0000;
      1:       w = 16'hFFFF;
      2:       w = 16'hFFFF << $urandom_range(1, 15);
      default: w = 16'($urandom);
    endcase
    return w;
  endfunction

  // drives sw as one stream; stall_at >= 0 holds out_ready low for 5
  // cycles once that many output words have been taken
  task automatic run_stream(input string tag, input int ready_pct,
                            input int valid_pct, input int stall_at);
    int n, idx, got, stall, cyc, budget;
    bit stalled_prev;
    logic [17:0] prev;
    n = sw.size();
    idx = 0; got = 0; stall = 0; cyc = 0;
    stalled_prev = 1'b0;
    prev = '0;
    budget = n * ((ready_pct >= 100) ? 40 : 400) + 200;
    build_model();
    out_q.delete();
    while ((got < exp_q.size()) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
      if (stalled_prev)
        chk({tag, "_hold"}, {14'd0, bus.out_valid, bus.out_last, bus.dout}, {14'd0, prev});
      bus.in_valid = (idx < n) && ($urandom_range(0, 99) < valid_pct);
      bus.din      = (idx < n) ? sw[idx] : 16'h0000;
      bus.in_last  = (idx == n - 1);
      if ((stall_at >= 0) && (got == stall_at) && bus.out_valid && (stall < 5)) begin
        bus.out_ready = 1'b0;
        stall++;
        chk({tag, "_stall_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      end else begin
        bus.out_ready = ($urandom_range(0, 99) < ready_pct);
      end
      #1;
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        out_q.push_back({bus.out_last, bus.dout});
        got++;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev = {bus.out_valid, bus.out_last, bus.dout};
    end
    chk({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    if (stall_at >= 0) chk({tag, "_stalls"}, 32'(stall), 32'd5);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_no_extra"}, {31'd0, bus.out_valid}, 32'd0);
    foreach (exp_q[i])
      chk($sformatf("%s[%0d]", tag, i),
          (i < out_q.size()) ? {15'd0, out_q[i]} : 32'hDEAD_BEEF, {15'd0, exp_q[i]});
  endtask

  task automatic reset_mid_scan();
    int cyc, acc, lasts;
    cyc = 0; acc = 0; lasts = 0;
    sw.delete();
    sw.push_back(16'hFFFF);
    sw.push_back(16'h0F0F);
    bus.out_ready = 1'b1;
    while ((acc < 2) && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b1;
      bus.din = sw[acc];
      bus.in_last = 1'b0;
      #1;
      if (bus.out_valid && bus.out_last) lasts++;
      if (bus.in_ready) acc++;
    end
    chk("rst_mid_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("rst_mid_scanning", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_mid_dout", {16'd0, bus.dout}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_mid_no_last", 32'(lasts), 32'd0);
  endtask

  initial begin
    bus.din = '0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_dout", {16'd0, bus.dout}, 32'd0);
    chk("rst_in_ready_high", {31'd0, bus.in_ready}, 32'd1);

    sw.delete(); sw.push_back(16'h00FF);
    run_stream("w00ff", 100, 100, 1);

    sw.delete(); sw.push_back(16'h0000); sw.push_back(16'h0000);
    run_stream("span", 100, 100, -1);

    sw.delete(); sw.push_back(16'hAAAA);
    run_stream("alt", 100, 100, 7);

    sw.delete(); sw.push_back(16'hFFFF);
    run_stream("uni1", 100, 100, -1);

    for (int s = 0; s < 8; s++) begin
      sw.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) sw.push_back(rand_word());
      run_stream($sformatf("rnd%0d", s), 60, 70, (s == 0) ? 2 : -1);
    end

    reset_mid_scan();
    sw.delete(); sw.push_back(16'h0F0F); sw.push_back(16'h1234);
    run_stream("after_rst", 80, 80, -1);

    sw.delete();
    for (int k = 0; k < 4097; k++) sw.push_back(16'hFFFF);
    sw.push_back(16'h0000);
    run_stream("sat", 100, 100, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
